stf_seq: RTL
============

Name: stf_seq

Overview:
- Sequences the 16-entry short-training-field ROM to produce the full 802.11 STF preamble (default 10 repetitions = 160 I/Q samples).
- Sits directly downstream of the STF ROM: drives its 4-bit address and registers its 32-bit combinational output.
- Delivers samples on a valid/ready stream to the preamble/packet mux in openofdm_tx.
- Pulses done when the last sample has been accepted.

Parameters:
- NUM_REP, 10, number of 16-sample STF periods emitted (legal range 1..15).
- REP_W, 4, width of the repetition counter (must hold NUM_REP-1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sequence when IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- rom_addr  out  4  address to the STF ROM.
- rom_dout  in  32  ROM word: [31:16] I, [15:0] Q, two's complement.
- o_data  out  32  output sample, same packing as rom_dout.
- o_valid  out  1  o_data is valid.
- o_ready  in  1  downstream accepts when o_valid && o_ready.
- o_last  out  1  high with the final sample of the sequence.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the cycle after the final handshake.

Behaviour:
Reset values: all outputs 0; state IDLE; addr counter and rep counter 0.

States:
- IDLE → RUN on start.
- RUN → DRAIN when the final ROM word has been loaded.
- DRAIN → DONE when the final sample's handshake occurs.
- DONE → IDLE unconditionally after one cycle; done = 1 only in DONE.

Output register:
- Loads when !o_valid || o_ready (output register free).
- In RUN, load takes o_data ← rom_dout at the current rom_addr, then advances rom_addr.
- Latency: first sample valid 1 cycle after start is sampled.
- With o_ready held high: one sample per cycle; o_valid continuous for NUM_REP*16 cycles.

Counters:
- rom_addr wraps 15 → 0; rep increments on the wrap.
- The final load is at rep = NUM_REP-1, addr = 15; o_last is set with that load.
- In IDLE, rom_addr = 0.

Backpressure:
- While o_valid && !o_ready: o_data, o_last and rom_addr hold and no counter advances.
- o_valid never drops without a handshake except on abort.

Boundary cases:
- start while busy: ignored.
- start and abort in the same cycle: abort wins; stay or return to IDLE.
- abort: next cycle o_valid = 0, o_last = 0, counters = 0, state IDLE, no done pulse.
- Reset mid-sequence: asynchronous clear to reset values; no partial sample is presented afterwards.
- NUM_REP = 1: exactly 16 samples; o_last on addr 15.

Optional Feature:
Macro: STF_SEQ_WINDOW_EN

When defined (802.11 time-domain windowing):
- The first sample (rep 0, addr 0) is emitted with I and Q each arithmetic-shifted right by 1 (floor).
- One extra sample, equal to halved ROM word 0, is appended after the last period.
- Total = NUM_REP*16 + 1 samples; o_last moves to the appended sample.
- FSM: RUN → TAIL (load the halved tail word with rom_addr = 0) → DRAIN.

When undefined: no scaling, no tail sample, no TAIL state.

Decomposition:
Shared package (openofdm_tx_pkg) holds:
- STF_LEN = 16.
- Sample packing constants I_MSB = 31, I_LSB = 16, Q_MSB = 15, Q_LSB = 0.
- State enumeration typedef stf_seq_state_t {IDLE, RUN, TAIL, DRAIN, DONE}.
- A halve_iq function (per-component arithmetic shift right by 1).

Structure:
- The output register/handshake stage is one natural sub-module, stream_out_reg: data, valid, last, load-enable.
- The FSM and counters stay in stf_seq.
- The ROM stays external.

Test Plan:
1. Reset, start, o_ready = 1 → samples 0..159 match ROM[n mod 16] exactly: sample 0 = 32'hfd0e_fd0e, sample 1 = 32'hfe68_fc27, sample 16 = 32'hfd0e_fd0e, sample 159 = 32'hfc27_fe68 with o_last = 1; done pulses the following cycle; busy falls with it.
2. o_ready low for cycles 5..9 of the stream → sample 5 (32'h03d9_fe68) held stable with o_valid = 1 throughout; rom_addr frozen; total 160 handshakes, no duplicates or drops.
3. Abort at the 40th handshake → next cycle o_valid = 0 and busy = 0, no done; a subsequent start restarts at sample 32'hfd0e_fd0e.
4. start pulsed again at cycle 50 while busy → ignored; exactly 160 samples, one done.
5. STF_SEQ_WINDOW_EN defined → sample 0 = 32'hfe87_fe87, sample 1 = 32'hfe68_fc27 (unscaled), 161 samples total, sample 160 = 32'hfe87_fe87 with o_last = 1.
6. NUM_REP = 1 → 16 samples; o_last on 32'hfc27_fe68; done one cycle later. rstn asserted mid-run → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/openofdm_tx_pkg.sv
// Shared types and helpers for the openofdm_tx preamble path.
// Samples are packed as {I[15:0], Q[15:0]}, both two's complement.
package openofdm_tx_pkg;

   localparam int unsigned STF_LEN = 16;

   localparam int unsigned I_MSB = 31;
   localparam int unsigned I_LSB = 16;
   localparam int unsigned Q_MSB = 15;
   localparam int unsigned Q_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      TAIL,
      DRAIN,
      DONE
   } stf_seq_state_t;

   // Arithmetic shift right by one on I and Q independently (rounds toward -inf).
   function automatic logic [31:0] halve_iq(input logic [31:0] w);
      logic [15:0] i_h;
      logic [15:0] q_h;
      i_h = {w[I_MSB], w[I_MSB:I_LSB+1]};
      q_h = {w[Q_MSB], w[Q_MSB:Q_LSB+1]};
      return {i_h, q_h};
   endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register. Accepts a new word whenever it is
// empty or its current word is being taken downstream in the same cycle.
module stream_out_reg #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             free_o,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   output logic             last_o
);

   logic [Width-1:0] data_q;
   logic             valid_q;
   logic             last_q;

   assign free_o  = !valid_q || ready_i;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;

   // Output word register; clr_i drops any pending word without a handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (clr_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (free_o) begin
         valid_q <= push_i;
         last_q  <= push_i && last_i;
         if (push_i) begin
            data_q <= data_i;
         end
      end
   end

endmodule

// File: rtl/stf_seq.sv
// STF preamble sequencer: walks the external 16-entry STF ROM NUM_REP times and
// streams the words out on a valid/ready interface, pulsing done afterwards.
// Optional build macro STF_SEQ_WINDOW_EN halves the first sample and appends a
// halved copy of ROM word 0 as an extra final sample.
module stf_seq
   import openofdm_tx_pkg::*;
#(
   parameter int unsigned NUM_REP = 10,
   parameter int unsigned REP_W   = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  rom_addr,
   input  logic [31:0] rom_dout,
   output logic [31:0] o_data,
   output logic        o_valid,
   input  logic        o_ready,
   output logic        o_last,
   output logic        busy,
   output logic        done
);

   localparam logic [REP_W-1:0] LastRep  = REP_W'(NUM_REP - 1);
   localparam logic [3:0]       LastAddr = 4'(STF_LEN - 1);

   stf_seq_state_t   state_q, state_d;
   logic [3:0]       addr_q, addr_d;
   logic [REP_W-1:0] rep_q, rep_d;

   logic        out_free;
   logic        push;
   logic        push_last;
   logic [31:0] push_data;
   logic        final_word;

   assign final_word = (rep_q == LastRep) && (addr_q == LastAddr);

   // Next-state, counter advance and output-register load control.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rep_d     = rep_q;
      push      = 1'b0;
      push_last = 1'b0;
      push_data = rom_dout;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (out_free) begin
               push   = 1'b1;
`ifdef STF_SEQ_WINDOW_EN
               if ((rep_q == '0) && (addr_q == '0)) begin
                  push_data = halve_iq(rom_dout);
               end
`else
               push_last = final_word;
`endif
               addr_d = addr_q + 4'd1;
               if (addr_q == LastAddr) begin
                  rep_d = rep_q + 1'b1;
               end
               if (final_word) begin
                  rep_d = '0;
`ifdef STF_SEQ_WINDOW_EN
                  state_d = TAIL;
`else
                  state_d = DRAIN;
`endif
               end
            end
         end
`ifdef STF_SEQ_WINDOW_EN
         TAIL: begin
            // addr has already wrapped to 0, so rom_dout is word 0 here
            if (out_free) begin
               push      = 1'b1;
               push_data = halve_iq(rom_dout);
               push_last = 1'b1;
               state_d   = DRAIN;
            end
         end
`endif
         DRAIN: begin
            // Only the final sample can still be in the register here
            if (o_valid && o_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d = IDLE;
         addr_d  = '0;
         rep_d   = '0;
         push    = 1'b0;
      end
   end

   // FSM state and ROM walk counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rep_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rep_q   <= rep_d;
      end
   end

   stream_out_reg #(
      .Width (32)
   ) u_out (
      .clk_i   (clk),
      .rst_ni  (rstn),
      .clr_i   (abort),
      .push_i  (push),
      .data_i  (push_data),
      .last_i  (push_last),
      .ready_i (o_ready),
      .free_o  (out_free),
      .data_o  (o_data),
      .valid_o (o_valid),
      .last_o  (o_last)
   );

   assign rom_addr = addr_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule
